pc_fetch_unit: RTL and testbench
================================

# pc_fetch_unit

Program counter and instruction fetch stage of the 16-bit datapath. Holds the PC and runs a request/acknowledge fetch from instruction memory. Presents the fetched instruction to decode, and computes the next PC as sequential, branch-relative or jump. It consumes the 16-bit output of `sign_extender`: that block widens the 8-bit branch offset from the decoded instruction into the `imm_ext` input used here.

## Interface
- `RESET_PC`, 16'h0000, PC value loaded on reset; bit 0 must be 0.
- `TIMEOUT`, 15, maximum cycles in FETCH without `imem_ack` before error; range 1–15 (4-bit counter).
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `imem_req`  out  1  fetch request, registered.
- `imem_addr`  out  16  fetch address; always equals `pc`.
- `imem_ack`  in  1  memory has driven `imem_rdata` this cycle; ignored while `imem_req`=0.
- `imem_rdata`  in  16  instruction word.
- `instr`  out  16  fetched instruction, registered.
- `instr_valid`  out  1  `instr` holds an unconsumed instruction.
- `instr_ready`  in  1  decode accepts `instr`.
- `stall`  in  1  hazard stall; blocks consumption.
- `branch_taken`  in  1  take branch using `imm_ext`.
- `imm_ext`  in  16  sign-extended branch offset, in words.
- `jump`  in  1  absolute jump.
- `jump_target`  in  16  jump address; bit 0 forced to 0.
- `pc`  out  16  current PC.
- `fetch_err`  out  1  sticky fetch-timeout error.

## Operation
FSM states: IDLE, FETCH, HOLD, ERROR. All outputs are registered.
- Reset values: state=IDLE, `pc`=RESET_PC, `instr`=0, `instr_valid`=0, `imem_req`=0, `fetch_err`=0, timeout counter=0.
- **IDLE:** unconditional transition to FETCH; set `imem_req`<=1.
- **FETCH:** `imem_req`=1; `imem_addr` stays stable until ack.
  - On `imem_ack`: `instr`<=`imem_rdata`, `instr_valid`<=1, `imem_req`<=0, counter<=0, go to HOLD.
  - Otherwise: counter increments.
- **Timeout:** if counter = TIMEOUT−1 and no ack in that cycle: `imem_req`<=0, `fetch_err`<=1, go to ERROR. An ack in that same cycle wins and the fetch completes normally.
- **HOLD:** consumption occurs when `instr_ready`=1 and `stall`=0. On consumption:
  - `instr_valid`<=0, `imem_req`<=1, go to FETCH.
  - `pc` update, first match wins:
    - `jump`: `pc`<=`{jump_target[15:1],1'b0}`
    - else `branch_taken`: `pc`<=`pc + 2 + (imm_ext<<1)`
    - else: `pc`<=`pc + 2`
  - `instr` keeps its value until the next ack.
- `jump`, `branch_taken` and `imm_ext` are sampled only on the consumption edge; at all other times they are ignored.
- All PC arithmetic is 16-bit modulo 2^16 with no overflow flag; `pc` bit 0 is always 0.
- **ERROR:** terminal state. Outputs frozen, `imem_req`=0, `fetch_err`=1; only `rst_n` exits.
- **Reset mid-operation:** asserting `rst_n` in any state, including FETCH with an outstanding request, returns all registers to their reset values immediately. A late `imem_ack` after reset is ignored because `imem_req`=0.

## Timing
- **First request:** `imem_req` rises on the first rising edge after `rst_n` deasserts, with `imem_addr`=RESET_PC.
- **Fetch latency:** ack sampled at edge N gives `instr_valid`=1 and the new `instr` after edge N. An ack in the first FETCH cycle is legal.
- **Redirect latency:** consumption at edge M gives the new `pc`/`imem_addr` and `imem_req`=1 after edge M.
- **Throughput:** best case is one instruction per 2 cycles (one FETCH cycle, one HOLD cycle).
- **Stall:** while `stall`=1 or `instr_ready`=0 in HOLD, `pc`, `instr` and `instr_valid` hold indefinitely.
- **Timeout bound:** `fetch_err` rises exactly TIMEOUT cycles after entering FETCH if no ack arrives.

## Test plan
- Reset/startup: `rst_n`=0 → `pc`=0x0000, `instr_valid`=0, `imem_req`=0; release → `imem_req`=1, `imem_addr`=0x0000 after 1 edge.
- Sequential fetch: ack with `imem_rdata`=0x1234 → `instr`=0x1234, `instr_valid`=1; `instr_ready`=1 → `pc`=0x0002, `imem_req`=1.
- Branch: at `pc`=0x0010, `branch_taken`=1, `imm_ext`=0xFFFF (the sign_extender result for input 0xFF) → `pc`=0x0010. With `imm_ext`=0x0003 → `pc`=0x0018. With `imm_ext`=0x0000 → `pc`=0x0012.
- Priority and wrap:
  - `jump`=1, `jump_target`=0x0101 and `branch_taken`=1 together → `pc`=0x0100.
  - Sequential step from `pc`=0xFFFE → `pc`=0x0000.
- Stall: HOLD with `instr_ready`=1 and `stall`=1 for 3 cycles → `pc`, `instr` and `instr_valid`=1 unchanged. Dropping `stall` → consumed on the next edge.
- Timeout: TIMEOUT=15, no ack → `fetch_err`=1 and `imem_req`=0 after 15 FETCH cycles, state holds. Ack in the 15th cycle → normal HOLD with `fetch_err`=0. `rst_n` pulse in ERROR → reset values restored.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch stage for the 16-bit datapath.
// Runs a req/ack fetch from instruction memory, holds the fetched word for
// decode, and advances the PC (sequential, branch-relative or jump) when
// decode consumes the instruction. A fetch that never acks is a sticky error.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | one cycle after reset; raises the first request
// FETCH | request outstanding at pc, waiting for imem_ack (timeout armed)
// HOLD  | instr valid, waiting for decode to consume it
// ERROR | fetch timed out; frozen until rst_n
module pc_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic [15:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] imm_ext,
    input  logic        jump,
    input  logic [15:0] jump_target,
    output logic [15:0] pc,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        ERROR = 2'd3
    } state_t;

    // Last counter value before the timeout fires; TIMEOUT is limited to 1..15.
    localparam logic [3:0]  TMO_LAST = 4'(TIMEOUT - 1);
    // Bit 0 is cleared so pc stays word-aligned even with an odd RESET_PC.
    localparam logic [15:0] PC_INIT  = {RESET_PC[15:1], 1'b0};

    state_t      state;
    logic [3:0]  tmo_cnt;
    logic [15:0] pc_next;
    logic        consume;

    assign imem_addr = pc;
    assign consume   = (state == HOLD) && instr_ready && !stall;

    // Next PC on consumption: jump beats branch beats sequential, all mod 2^16.
    always_comb begin
        pc_next = pc + 16'd2;
        if (jump) begin
            pc_next = jump_target & 16'hFFFE;
        end else if (branch_taken) begin
            pc_next = pc + 16'd2 + (imm_ext << 1);
        end
    end

    // Fetch FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= PC_INIT;
            instr       <= 16'h0000;
            instr_valid <= 1'b0;
            imem_req    <= 1'b0;
            fetch_err   <= 1'b0;
            tmo_cnt     <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    imem_req <= 1'b1;
                    state    <= FETCH;
                end
                FETCH: begin
                    if (imem_ack) begin
                        // An ack on the timeout cycle still completes the fetch.
                        instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        tmo_cnt     <= 4'd0;
                        state       <= HOLD;
                    end else if (tmo_cnt == TMO_LAST) begin
                        imem_req  <= 1'b0;
                        fetch_err <= 1'b1;
                        state     <= ERROR;
                    end else begin
                        tmo_cnt <= tmo_cnt + 4'd1;
                    end
                end
                HOLD: begin
                    if (consume) begin
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                        pc          <= pc_next;
                        state       <= FETCH;
                    end
                end
                ERROR: begin
                    state <= ERROR;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed plan steps plus randomized fetch/consume
// rounds, checked against a transaction-level model of the PC and instruction.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        stall;
    logic        branch_taken;
    logic [15:0] imm_ext;
    logic        jump;
    logic [15:0] jump_target;
    logic [15:0] pc;
    logic        fetch_err;

    int errors = 0;
    int checks = 0;

    // reference model state
    int          mpc;
    logic [15:0] minstr;

    pc_fetch_unit #(.RESET_PC(16'h0000), .TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .stall(stall),
        .branch_taken(branch_taken), .imm_ext(imm_ext),
        .jump(jump), .jump_target(jump_target),
        .pc(pc), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Architectural next-PC rule in plain signed integer arithmetic.
    function automatic int ref_next(int cur, bit j, logic [15:0] jt, bit br, logic [15:0] imm);
        int n;
        if (j)       n = int'(jt) - (int'(jt) % 2);
        else if (br) n = cur + 2 + 2 * int'($signed(imm));
        else         n = cur + 2;
        return ((n % 65536) + 65536) % 65536;
    endfunction

    task automatic clear_ctl();
        instr_ready  = 1'b0;
        stall        = 1'b0;
        jump         = 1'b0;
        branch_taken = 1'b0;
        imm_ext      = 16'h0000;
        jump_target  = 16'h0000;
    endtask

    // In FETCH: hold off ack for 'waits' cycles, then ack with 'data'.
    task automatic do_fetch(input logic [15:0] data, input int waits);
        for (int i = 0; i < waits; i++) begin
            chk("fetch_req", {15'd0, imem_req}, 16'd1);
            chk("fetch_addr", imem_addr, 16'(mpc));
            imem_rdata = 16'($urandom);
            tick();
        end
        imem_ack   = 1'b1;
        imem_rdata = data;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 16'($urandom);
        minstr     = data;
        chk("fetch_instr", instr, minstr);
        chk("fetch_valid", {15'd0, instr_valid}, 16'd1);
        chk("fetch_req_drop", {15'd0, imem_req}, 16'd0);
        chk("fetch_err_clear", {15'd0, fetch_err}, 16'd0);
    endtask

    // In HOLD: block consumption for nstall cycles (mode 1: ready=1/stall=1,
    // mode 0: random blocking mix), driving noise on the redirect inputs,
    // then consume with the given redirect.
    task automatic do_consume(input bit j, input logic [15:0] jt, input bit br,
                              input logic [15:0] imm, input int nstall, input bit mode);
        for (int i = 0; i < nstall; i++) begin
            if (mode) begin
                instr_ready = 1'b1;
                stall       = 1'b1;
            end else begin
                instr_ready = 1'($urandom_range(0, 1));
                stall       = instr_ready ? 1'b1 : 1'($urandom_range(0, 1));
            end
            jump         = 1'($urandom_range(0, 1));
            branch_taken = 1'($urandom_range(0, 1));
            imm_ext      = 16'($urandom);
            jump_target  = 16'($urandom);
            tick();
            chk("stall_pc", pc, 16'(mpc));
            chk("stall_instr", instr, minstr);
            chk("stall_valid", {15'd0, instr_valid}, 16'd1);
        end
        instr_ready  = 1'b1;
        stall        = 1'b0;
        jump         = j;
        jump_target  = jt;
        branch_taken = br;
        imm_ext      = imm;
        tick();
        clear_ctl();
        mpc = ref_next(mpc, j, jt, br, imm);
        chk("cons_pc", pc, 16'(mpc));
        chk("cons_addr", imem_addr, 16'(mpc));
        chk("cons_req", {15'd0, imem_req}, 16'd1);
        chk("cons_valid", {15'd0, instr_valid}, 16'd0);
        chk("cons_instr_kept", instr, minstr);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pc"}, pc, 16'h0000);
        chk({tag, "_valid"}, {15'd0, instr_valid}, 16'd0);
        chk({tag, "_req"}, {15'd0, imem_req}, 16'd0);
        chk({tag, "_err"}, {15'd0, fetch_err}, 16'd0);
        chk({tag, "_instr"}, instr, 16'h0000);
    endtask

    initial begin
        logic [7:0] off8;
        rst_n      = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 16'h0000;
        clear_ctl();
        mpc    = 0;
        minstr = 16'h0000;

        // reset and startup
        #3;
        chk_reset_vals("rst");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("start_req", {15'd0, imem_req}, 16'd1);
        chk("start_addr", imem_addr, 16'h0000);

        // sequential fetch, ack in the first FETCH cycle
        do_fetch(16'h1234, 0);
        do_consume(1'b0, 16'h0000, 1'b0, 16'h0000, 0, 1'b0);
        chk("seq_pc2", pc, 16'h0002);

        // branch cases from pc 0x0010
        do_fetch(16'hA001, 2);
        do_consume(1'b1, 16'h0010, 1'b0, 16'h0000, 0, 1'b0);
        do_fetch(16'hA002, 1);
        do_consume(1'b0, 16'h0000, 1'b1, 16'hFFFF, 0, 1'b0);
        chk("br_m1", pc, 16'h0010);
        do_fetch(16'hA003, 0);
        do_consume(1'b0, 16'h0000, 1'b1, 16'h0003, 0, 1'b0);
        chk("br_p3", pc, 16'h0018);
        do_fetch(16'hA004, 0);
        do_consume(1'b1, 16'h0010, 1'b0, 16'h0000, 0, 1'b0);
        do_fetch(16'hA005, 0);
        do_consume(1'b0, 16'h0000, 1'b1, 16'h0000, 0, 1'b0);
        chk("br_0", pc, 16'h0012);

        // jump beats branch, odd target is aligned
        do_fetch(16'hB001, 0);
        do_consume(1'b1, 16'h0101, 1'b1, 16'h0040, 0, 1'b0);
        chk("jmp_prio", pc, 16'h0100);

        // wrap at the top of the address space
        do_fetch(16'hB002, 0);
        do_consume(1'b1, 16'hFFFE, 1'b0, 16'h0000, 0, 1'b0);
        do_fetch(16'hB003, 0);
        do_consume(1'b0, 16'h0000, 1'b0, 16'h0000, 0, 1'b0);
        chk("wrap", pc, 16'h0000);

        // three-cycle hazard stall, then consume
        do_fetch(16'hC0DE, 1);
        do_consume(1'b0, 16'h0000, 1'b0, 16'h0000, 3, 1'b1);

        // randomized rounds
        for (int r = 0; r < 24; r++) begin
            off8 = 8'($urandom);
            do_fetch(16'($urandom), int'($urandom_range(0, 6)));
            do_consume(1'($urandom_range(0, 3) == 0), 16'($urandom),
                       1'($urandom_range(0, 1)), {{8{off8[7]}}, off8},
                       int'($urandom_range(0, 3)), 1'b0);
        end

        // ack on the last possible cycle still completes
        do_fetch(16'h5A5A, 14);
        do_consume(1'b0, 16'h0000, 1'b0, 16'h0000, 0, 1'b0);

        // no ack: error after exactly 15 FETCH cycles
        for (int i = 0; i < 14; i++) tick();
        chk("tmo_pre_err", {15'd0, fetch_err}, 16'd0);
        chk("tmo_pre_req", {15'd0, imem_req}, 16'd1);
        tick();
        chk("tmo_err", {15'd0, fetch_err}, 16'd1);
        chk("tmo_req", {15'd0, imem_req}, 16'd0);

        // ERROR is terminal regardless of inputs
        imem_ack    = 1'b1;
        instr_ready = 1'b1;
        jump        = 1'b1;
        jump_target = 16'h4444;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("err_hold_err", {15'd0, fetch_err}, 16'd1);
            chk("err_hold_req", {15'd0, imem_req}, 16'd0);
            chk("err_hold_pc", pc, 16'(mpc));
            chk("err_hold_instr", instr, minstr);
            chk("err_hold_valid", {15'd0, instr_valid}, 16'd0);
        end

        // async reset out of ERROR, ack still high across release is ignored
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("err_rst");
        clear_ctl();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rel_req", {15'd0, imem_req}, 16'd1);
        chk("rel_addr", imem_addr, 16'h0000);
        chk("rel_valid", {15'd0, instr_valid}, 16'd0);
        imem_ack = 1'b0;
        mpc = 0;

        // reset with a request outstanding
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("fetch_rst");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        do_fetch(16'h7E57, 0);
        do_consume(1'b0, 16'h0000, 1'b0, 16'h0000, 0, 1'b0);
        chk("post_rst_pc", pc, 16'h0002);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
